rom_dl_ctrl: RTL
================

ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

Interface
REQ-001 Parameter ROM_BYTES, 17'h1_0000, number of valid ROM image bytes; writes at or above this address are dropped.
REQ-002 Parameter HOLD_CYCLES, 16, number of clk_sys cycles the core stays in reset after download ends (range 1..255).
REQ-003 clk_sys  in  1  system clock (12 MHz); all logic on its rising edge.
REQ-004 Reset_n  in  1  reset, asynchronous, active-low.
REQ-005 ioctl_download  in  1  HPS download window active.
REQ-006 ioctl_wr  in  1  single-cycle byte-write strobe from HPS.
REQ-007 ioctl_addr  in  25  byte address of the current write.
REQ-008 ioctl_data  in  8  byte value of the current write.
REQ-009 dn_addr  out  17  registered ROM write address to the game core.
REQ-010 dn_data  out  8  registered ROM write data.
REQ-011 dn_wr  out  1  registered ROM write strobe, one cycle per accepted byte.
REQ-012 core_reset_n  out  1  active-low reset to the game core.
REQ-013 dl_done  out  1  one-cycle pulse when the core is released after a good download.
REQ-014 rom_valid  out  1  sticky: a complete image has been loaded since reset.
REQ-015 dl_overflow  out  1  sticky per download: at least one write was dropped as out of range.
REQ-016 byte_count  out  17  accepted bytes in the current or last download (saturates at 17'h1_FFFF).

Function
REQ-017 FSM states: EMPTY, LOAD, HOLD, RUN; a single state register.
REQ-018 EMPTY: core_reset_n=0; go to LOAD when ioctl_download=1.
REQ-019 LOAD: core_reset_n=0; on entry, clear byte_count and dl_overflow.
REQ-020 LOAD, ioctl_wr=1 and ioctl_addr<ROM_BYTES: on the next cycle, dn_wr=1, dn_addr=ioctl_addr[16:0] and dn_data=ioctl_data; byte_count increments; latency is exactly 1 cycle.
REQ-021 LOAD, ioctl_wr=1 and ioctl_addr>=ROM_BYTES (including any nonzero bits in [24:17]): dn_wr stays 0, byte_count is unchanged, and dl_overflow is set.
REQ-022 ioctl_wr outside LOAD: ignored; dn_wr stays 0.
REQ-023 LOAD, ioctl_download falls: if byte_count>0 (including a write accepted in that same cycle), go to HOLD and load the hold counter with HOLD_CYCLES-1; otherwise go to EMPTY if rom_valid=0, or to HOLD if rom_valid=1.
REQ-024 HOLD: core_reset_n=0; counter decrements every cycle; at 0 go to RUN and set rom_valid.
REQ-025 dl_done pulses in the first RUN cycle only when entry came from a download with byte_count>0.
REQ-026 HOLD, ioctl_download rises: abandon the hold and go to LOAD; no dl_done pulse.
REQ-027 RUN: core_reset_n=1; go to LOAD when ioctl_download rises (core re-enters reset the following cycle).
REQ-028 dn_addr and dn_data hold their last values when dn_wr=0.
REQ-029 A single-cycle ioctl_download pulse in EMPTY or RUN is still captured: LOAD is entered.

Reset
REQ-030 Reset_n=0: state=EMPTY, core_reset_n=0, dn_wr=0, dn_addr=0, dn_data=0, dl_done=0, rom_valid=0, dl_overflow=0, byte_count=0, hold counter=0.
REQ-031 Reset_n asserted mid-LOAD or mid-HOLD: all outputs take reset values immediately; any partial image is not valid.
REQ-032 After release, the block waits in EMPTY and needs a new download before core_reset_n goes high.

Structure
REQ-033 A shared package sprint1_pkg holds the state enum (dl_state_t), ROM address width (17) and the default ROM_BYTES.
REQ-034 One sub-module, dl_hold_timer: a loadable down-counter with a zero flag used for HOLD; everything else is inline.

Verification
REQ-035 Reset, then download 4 bytes at addresses 0..3 with values A5,5A,00,FF -> each dn_wr one cycle after its ioctl_wr with matching addr/data; core_reset_n rises exactly HOLD_CYCLES cycles after download falls; dl_done pulses once; byte_count=4.
REQ-036 Write at 0x1_0000 and 0x0_0010 during one download -> only 0x0010 is forwarded; dl_overflow=1; byte_count=1.
REQ-037 Download with zero writes from EMPTY -> returns to EMPTY; core_reset_n stays 0; no dl_done.
REQ-038 RUN, then a new download starts -> core_reset_n=0 the next cycle; byte_count and dl_overflow clear; rom_valid stays 1.
REQ-039 Reset_n low during LOAD after 100 bytes -> all outputs at reset values; after release, rom_valid=0 and core_reset_n=0.
REQ-040 ioctl_download rises again during HOLD (HOLD_CYCLES=16, at count 5) -> LOAD is re-entered; no dl_done; the release timing restarts after the second download.

Source files
------------

// File: rtl/sprint1_pkg.sv
// Shared types and constants for the ROM download controller.
// Holds the FSM state encoding, the ROM address width and the default image size.
package sprint1_pkg;

    localparam int ROM_ADDR_W = 17;
    localparam int HOLD_W     = 8;
    localparam logic [ROM_ADDR_W-1:0] DEF_ROM_BYTES = 17'h1_0000;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } dl_state_t;

    // Any set bit above the ROM address range is out of range regardless of the low bits.
    function automatic logic addr_in_rom(input logic [24:0] addr,
                                         input logic [ROM_ADDR_W-1:0] rom_bytes);
        return (addr[24:ROM_ADDR_W] == '0) && (addr[ROM_ADDR_W-1:0] < rom_bytes);
    endfunction

endpackage

// File: rtl/rom_dl_ctrl_if.sv
// HPS ioctl write stream in, registered ROM write stream out to the game core.
// No backpressure: the HPS side is fire-and-forget, one byte per strobe.
interface rom_dl_ctrl_if;
    import sprint1_pkg::*;

    logic                  ioctl_download;
    logic                  ioctl_wr;
    logic [24:0]           ioctl_addr;
    logic [7:0]            ioctl_data;
    logic [ROM_ADDR_W-1:0] dn_addr;
    logic [7:0]            dn_data;
    logic                  dn_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
        input  dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
        output dn_addr, dn_data, dn_wr
    );

endinterface

// File: rtl/dl_hold_timer.sv
// Loadable down-counter with zero flag; counts the post-download reset hold.
// Load wins over decrement; the count stops at zero. No backpressure.
module dl_hold_timer #(
    parameter int W = 8
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rom_dl_ctrl.sv
// Forwards HPS ROM download bytes to the core and sequences the core reset around it.
// Write path latency 1 cycle; no backpressure, out-of-range bytes are dropped and flagged.
module rom_dl_ctrl
    import sprint1_pkg::*;
#(
    parameter logic [ROM_ADDR_W-1:0] ROM_BYTES   = DEF_ROM_BYTES,
    parameter int                    HOLD_CYCLES = 16
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    rom_dl_ctrl_if.slave          bus,
    output logic                  core_reset_n,
    output logic                  dl_done,
    output logic                  rom_valid,
    output logic                  dl_overflow,
    output logic [ROM_ADDR_W-1:0] byte_count
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    dl_state_t state;
    logic      hold_from_dl;
    logic      accept;
    logic      got_bytes;
    logic      timer_load;
    logic      timer_zero;

    assign accept     = (state == ST_LOAD) && bus.ioctl_wr && addr_in_rom(bus.ioctl_addr, ROM_BYTES);
    // A byte accepted in the same cycle the window closes still counts as a real download.
    assign got_bytes  = (byte_count != '0) || accept;
    assign timer_load = (state == ST_LOAD) && !bus.ioctl_download && (got_bytes || rom_valid);

    dl_hold_timer #(.W(HOLD_W)) u_hold_timer (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (HOLD_LOAD),
        .dec      (state == ST_HOLD),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_EMPTY;
            core_reset_n <= 1'b0;
            bus.dn_wr    <= 1'b0;
            bus.dn_addr  <= '0;
            bus.dn_data  <= '0;
            dl_done      <= 1'b0;
            rom_valid    <= 1'b0;
            dl_overflow  <= 1'b0;
            byte_count   <= '0;
            hold_from_dl <= 1'b0;
        end else begin
            bus.dn_wr <= 1'b0;
            dl_done   <= 1'b0;
            case (state)
                ST_EMPTY: begin
                    core_reset_n <= 1'b0;
                    if (bus.ioctl_download) begin
                        state       <= ST_LOAD;
                        byte_count  <= '0;
                        dl_overflow <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    core_reset_n <= 1'b0;
                    if (accept) begin
                        bus.dn_wr   <= 1'b1;
                        bus.dn_addr <= bus.ioctl_addr[ROM_ADDR_W-1:0];
                        bus.dn_data <= bus.ioctl_data;
                        if (byte_count != '1) begin
                            byte_count <= byte_count + 1'b1;
                        end
                    end else if (bus.ioctl_wr) begin
                        dl_overflow <= 1'b1;
                    end
                    if (!bus.ioctl_download) begin
                        if (got_bytes) begin
                            state        <= ST_HOLD;
                            hold_from_dl <= 1'b1;
                        end else if (rom_valid) begin
                            state        <= ST_HOLD;
                            hold_from_dl <= 1'b0;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.ioctl_download) begin
                        state        <= ST_LOAD;
                        core_reset_n <= 1'b0;
                        byte_count   <= '0;
                        dl_overflow  <= 1'b0;
                    end else if (timer_zero) begin
                        state        <= ST_RUN;
                        core_reset_n <= 1'b1;
                        rom_valid    <= 1'b1;
                        dl_done      <= hold_from_dl;
                    end else begin
                        core_reset_n <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.ioctl_download) begin
                        state        <= ST_LOAD;
                        core_reset_n <= 1'b0;
                        byte_count   <= '0;
                        dl_overflow  <= 1'b0;
                    end else begin
                        core_reset_n <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_EMPTY;
                    core_reset_n <= 1'b0;
                end
            endcase
        end
    end

endmodule
